// File: rtl/gray_pkg.sv
// Gray-code helper functions shared by the Gray counter, its receiver and their benches.
// Arguments are 32 bits wide; narrower callers zero-extend, which leaves the results unchanged.
package gray_pkg;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] x);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + int'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_counter_rx_sync_chain.sv
// Plain multi-flop synchronizer: stage 0 samples d directly, with no logic between stages.
module sync_chain #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_counter_rx.sv
// Receives a foreign-domain Gray count, synchronizes and decodes it, and reports step size,
// wrap-around and multi-bit-change errors.
//   state | meaning
//   FILL  | synchronizer flushing after reset; outputs hold reset values
//   PRIME | waiting for the first enabled sample; no step check
//   RUN   | decoding every enabled sample and checking it against the previous one
module gray_counter_rx
  import gray_pkg::*;
#(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     gray_i,
  input  logic             ena,
  output logic [W-1:0]     bin_o,
  output logic             bin_valid,
  output logic [W-1:0]     delta,
  output logic             wrap,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {FILL, PRIME, RUN} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t       state;
  logic [2:0]   fill_cnt;
  logic [W-1:0] g;
  logic [W-1:0] prev_gray;
  logic [W-1:0] bin_new;
  logic [W-1:0] delta_new;
  logic         multi_bit;

  sync_chain #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (gray_i),
    .q       (g)
  );

  assign bin_new   = W'(gray2bin(MAX_W'(g)));
  assign delta_new = bin_new - bin_o;
  assign multi_bit = popcount(MAX_W'(g ^ prev_gray)) > 1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FILL;
      fill_cnt  <= 3'(SYNC_STAGES - 1);
      bin_o     <= '0;
      prev_gray <= '0;
      delta     <= '0;
      err_cnt   <= '0;
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      step_err <= 1'b0;
      case (state)
        FILL: begin
          if (fill_cnt == 3'd0) state <= PRIME;
          else                  fill_cnt <= fill_cnt - 3'd1;
        end
        PRIME: begin
          if (ena) begin
            bin_o     <= bin_new;
            prev_gray <= g;
            bin_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (ena) begin
            bin_o     <= bin_new;
            delta     <= delta_new;
            prev_gray <= g;
            step_err  <= multi_bit;
            // A wrap is a forward move that lands numerically below the old count.
            wrap      <= (delta_new != '0) && (bin_new < bin_o);
            if (multi_bit && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_counter_rx.sv
// Randomized self-checking bench for gray_counter_rx against a delay-line/arithmetic reference model.
module tb_gray_counter_rx;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int EW = 8;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  gray_i;
  logic          ena;
  logic [W-1:0]  bin_o;
  logic          bin_valid;
  logic [W-1:0]  delta;
  logic          wrap;
  logic          step_err;
  logic [EW-1:0] err_cnt;

  gray_counter_rx #(.W(W), .SYNC_STAGES(SS), .ERR_W(EW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .gray_i    (gray_i),
    .ena       (ena),
    .bin_o     (bin_o),
    .bin_valid (bin_valid),
    .delta     (delta),
    .wrap      (wrap),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int m_bin, m_delta, m_prev, m_cnt, fill_left;
  bit m_valid, m_wrap, m_err;
  int hist[$];

  function automatic int to_gray(input int n);
    return (n ^ (n >> 1)) & 15;
  endfunction

  function automatic int decode(input int g);
    for (int n = 0; n < 16; n++) if (to_gray(n) == g) return n;
    return 0;
  endfunction

  task automatic model_edge(input int gv, input bit en, input bit rst);
    int g, nb, d;
    if (!rst) begin
      m_bin = 0; m_delta = 0; m_prev = 0; m_cnt = 0;
      m_valid = 0; m_wrap = 0; m_err = 0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back(0);
      fill_left = SS;
    end else begin
      g = hist.pop_front();
      hist.push_back(gv);
      m_wrap = 0;
      m_err  = 0;
      if (fill_left > 0) begin
        fill_left--;
      end else if (en) begin
        nb = decode(g);
        if (!m_valid) begin
          m_valid = 1;
          m_bin   = nb;
          m_prev  = g;
        end else begin
          d       = (nb - m_bin + 16) % 16;
          m_err   = $countones(g ^ m_prev) > 1;
          m_wrap  = (d != 0) && (nb < m_bin);
          if (m_err && m_cnt < 255) m_cnt++;
          m_delta = d;
          m_bin   = nb;
          m_prev  = g;
        end
      end
    end
  endtask

  task automatic cycle(input int gv, input bit en, input bit rst);
    gray_i  = W'(gv);
    ena     = en;
    reset_n = rst;
    @(posedge clk);
    model_edge(gv, en, rst);
    #1;
    chk("bin_o",     32'(bin_o),     32'(m_bin));
    chk("bin_valid", 32'(bin_valid), 32'(m_valid));
    chk("delta",     32'(delta),     32'(m_delta));
    chk("wrap",      32'(wrap),      32'(m_wrap));
    chk("step_err",  32'(step_err),  32'(m_err));
    chk("err_cnt",   32'(err_cnt),   32'(m_cnt));
  endtask

  initial begin
    int n, r;
    bit en, rst;

    cycle(0, 1, 0);
    cycle(0, 1, 0);

    // Counter stream: bin_valid after SS+1 edges, then 0,1,2,... with delta 1.
    for (int i = 0; i < 256; i++) cycle(to_gray(i), 1, 1);
    chk("stream_err_cnt", 32'(err_cnt), 0);

    // 1000 -> 0000 is a legal wrap; then jump 0000 -> 0011.
    for (int i = 0; i < 4; i++) cycle(0, 1, 1);
    chk("wrap_bin_zero", 32'(bin_o), 0);
    for (int i = 0; i < 3; i++) cycle(3, 1, 1);
    chk("bad_step_bin", 32'(bin_o), 2);
    chk("bad_step_cnt", 32'(err_cnt), 1);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) cycle((i % 2 == 0) ? 0 : 3, 1, 1);
    for (int i = 0; i < 3; i++) cycle(3, 1, 1);
    chk("sat_cnt", 32'(err_cnt), 255);

    // Enable gating: three steps while disabled.
    for (int i = 0; i < 4; i++) cycle(0, 1, 1);
    cycle(1, 0, 1);
    cycle(3, 0, 1);
    for (int i = 0; i < 8; i++) cycle(2, 0, 1);
    chk("gate_hold_bin", 32'(bin_o), 0);
    cycle(2, 1, 1);
    chk("gate_delta", 32'(delta), 3);

    // Reset while bin_o is 9.
    n = 3;
    for (int i = 0; i < 40 && m_bin != 9; i++) begin
      n = (n + 1) % 16;
      cycle(to_gray(n), 1, 1);
    end
    chk("pre_reset_bin", 32'(bin_o), 9);
    cycle(to_gray(n), 1, 0);
    chk("post_reset_bin", 32'(bin_o), 0);
    chk("post_reset_valid", 32'(bin_valid), 0);
    for (int i = 0; i < 20; i++) begin
      n = (n + 1) % 16;
      cycle(to_gray(n), 1, 1);
    end

    // Random mix of legal steps, holds, jumps, enable gaps and resets.
    for (int i = 0; i < 800; i++) begin
      r   = int'($urandom_range(0, 99));
      rst = ($urandom_range(0, 99) >= 2);
      en  = ($urandom_range(0, 3) != 0);
      if (r < 80)      n = (n + 1) % 16;
      else if (r < 92) n = n;
      else             n = int'($urandom_range(0, 15));
      cycle(to_gray(n), en, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
